// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the immediate generator: format codes, major opcodes
// and the datapath width legality check.
package imm_pkg;

  localparam logic [2:0] FMT_I       = 3'b000;
  localparam logic [2:0] FMT_S       = 3'b001;
  localparam logic [2:0] FMT_B       = 3'b010;
  localparam logic [2:0] FMT_J       = 3'b011;
  localparam logic [2:0] FMT_U       = 3'b100;
  localparam logic [2:0] FMT_Z       = 3'b101;
  localparam logic [2:0] FMT_NONE    = 3'b110;
  localparam logic [2:0] FMT_ILLEGAL = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational format resolution and immediate extension for one instruction.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter bit          DECODE_OPCODE = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_extend_core: XLEN must be 32 or 64");
  end

  localparam bit Rv64 = (XLEN == 64);

  logic        sgn;
  logic [63:0] imm_full;

  assign sgn = instr[31];

  always_comb begin
    fmt = FMT_ILLEGAL;
    if (DECODE_OPCODE) begin
      case (instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
        OP_IMM32:                 fmt = Rv64 ? FMT_I : FMT_ILLEGAL;
        OP_STORE:                 fmt = FMT_S;
        OP_BRANCH:                fmt = FMT_B;
        OP_JAL:                   fmt = FMT_J;
        OP_LUI, OP_AUIPC:         fmt = FMT_U;
        OP_SYSTEM:                fmt = instr[14] ? FMT_Z : FMT_I;
        OP_REG:                   fmt = FMT_NONE;
        OP_REG32:                 fmt = Rv64 ? FMT_NONE : FMT_ILLEGAL;
        default:                  fmt = FMT_ILLEGAL;
      endcase
    end else begin
      fmt = immsrc;
    end
  end

  // Built at 64 bits and truncated so both widths share one expression.
  always_comb begin
    imm_full = '0;
    case (fmt)
      FMT_I: imm_full = {{52{sgn}}, instr[31:20]};
      FMT_S: imm_full = {{52{sgn}}, instr[31:25], instr[11:7]};
      FMT_B: imm_full = {{51{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J: imm_full = {{43{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U: imm_full = {{32{sgn}}, instr[31:12], 12'b0};
      FMT_Z: imm_full = {59'b0, instr[19:15]};
      default: imm_full = '0;
    endcase
  end

  assign imm     = imm_full[XLEN-1:0];
  assign illegal = (fmt == FMT_ILLEGAL);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a two-entry output buffer (OUT + SKID) so that
// in_ready depends only on a flop.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned TAG_W         = 32,
  parameter bit          DECODE_OPCODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0] new_imm;
  logic [2:0]      new_fmt;
  logic            new_illegal;

  imm_extend_core #(
    .XLEN          (XLEN),
    .DECODE_OPCODE (DECODE_OPCODE)
  ) u_core (
    .instr   (in_instr),
    .immsrc  (in_immsrc),
    .imm     (new_imm),
    .fmt     (new_fmt),
    .illegal (new_illegal)
  );

  logic             out_valid_q, skid_valid_q;
  logic [XLEN-1:0]  out_imm_q, skid_imm_q;
  logic [2:0]       out_fmt_q, skid_fmt_q;
  logic             out_ill_q, skid_ill_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;

  logic accept, drain;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_I;
      out_ill_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_I;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_q <= 1'b1;
        out_imm_q   <= skid_imm_q;
        out_fmt_q   <= skid_fmt_q;
        out_ill_q   <= skid_ill_q;
        out_tag_q   <= skid_tag_q;
        // accept is always 0 here since in_ready = !skid_valid
        skid_valid_q <= accept;
        if (accept) begin
          skid_imm_q <= new_imm;
          skid_fmt_q <= new_fmt;
          skid_ill_q <= new_illegal;
          skid_tag_q <= in_tag;
        end
      end else begin
        out_valid_q  <= accept;
        skid_valid_q <= 1'b0;
        if (accept) begin
          out_imm_q <= new_imm;
          out_fmt_q <= new_fmt;
          out_ill_q <= new_illegal;
          out_tag_q <= in_tag;
        end
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_imm_q   <= new_imm;
      skid_fmt_q   <= new_fmt;
      skid_ill_q   <= new_illegal;
      skid_tag_q   <= in_tag;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: RV32, RV64 and external-format instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  logic [2:0]  in_immsrc;

  logic        r32_in_ready, r32_out_valid, r32_out_illegal;
  logic [31:0] r32_out_imm, r32_out_tag;
  logic [2:0]  r32_out_fmt;

  logic        r64_in_ready, r64_out_valid, r64_out_illegal;
  logic [63:0] r64_out_imm;
  logic [31:0] r64_out_tag;
  logic [2:0]  r64_out_fmt;

  logic        ex_in_ready, ex_out_valid, ex_out_illegal;
  logic [31:0] ex_out_imm, ex_out_tag;
  logic [2:0]  ex_out_fmt;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .DECODE_OPCODE(1'b1)) u_r32 (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (r32_in_ready), .in_instr (in_instr),
    .in_immsrc (in_immsrc), .in_tag (in_tag),
    .out_valid (r32_out_valid), .out_ready (out_ready), .out_imm (r32_out_imm),
    .out_fmt (r32_out_fmt), .out_illegal (r32_out_illegal), .out_tag (r32_out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .DECODE_OPCODE(1'b1)) u_r64 (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (r64_in_ready), .in_instr (in_instr),
    .in_immsrc (in_immsrc), .in_tag (in_tag),
    .out_valid (r64_out_valid), .out_ready (out_ready), .out_imm (r64_out_imm),
    .out_fmt (r64_out_fmt), .out_illegal (r64_out_illegal), .out_tag (r64_out_tag)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .DECODE_OPCODE(1'b0)) u_ext (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (ex_in_ready), .in_instr (in_instr),
    .in_immsrc (in_immsrc), .in_tag (in_tag),
    .out_valid (ex_out_valid), .out_ready (out_ready), .out_imm (ex_out_imm),
    .out_fmt (ex_out_fmt), .out_illegal (ex_out_illegal), .out_tag (ex_out_tag)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry for a single edge, then withdraw it.
  task automatic send(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] tag);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_immsrc = src;
    in_tag    = tag;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_immsrc = '0; in_tag = '0;
    #2;
    check("rst_out_valid", {63'b0, r32_out_valid}, 64'd0);
    check("rst_in_ready",  {63'b0, r32_in_ready}, 64'd1);
    check("rst_imm64",     r64_out_imm, 64'd0);
    check("rst_fmt",       {61'b0, r32_out_fmt}, 64'd0);
    check("rst_tag",       {32'b0, r32_out_tag}, 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // I-type, 1-cycle latency
    send(32'hFFF00093, 3'b000, 32'h0000_1000);
    check("i_valid", {63'b0, r32_out_valid}, 64'd1);
    check("i_imm32", {32'b0, r32_out_imm}, 64'h0000_0000_FFFF_FFFF);
    check("i_fmt",   {61'b0, r32_out_fmt}, 64'd0);
    check("i_imm64", r64_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("i_tag",   {32'b0, r32_out_tag}, 64'h1000);

    send(32'hFE112E23, 3'b001, 32'h0000_1004);
    check("s_imm32", {32'b0, r32_out_imm}, 64'hFFFF_FFFC);
    check("s_fmt",   {61'b0, r32_out_fmt}, 64'd1);
    check("ext_s_imm", {32'b0, ex_out_imm}, 64'hFFFF_FFFC);
    check("ext_s_fmt", {61'b0, ex_out_fmt}, 64'd1);

    send(32'hFE000EE3, 3'b000, 32'h0000_1008);
    check("b_imm32", {32'b0, r32_out_imm}, 64'hFFFF_FFFC);
    check("b_fmt",   {61'b0, r32_out_fmt}, 64'd2);

    send(32'h0080006F, 3'b000, 32'h0000_100C);
    check("j_imm32", {32'b0, r32_out_imm}, 64'd8);
    check("j_fmt",   {61'b0, r32_out_fmt}, 64'd3);

    send(32'h123452B7, 3'b000, 32'h0000_1010);
    check("u_imm32", {32'b0, r32_out_imm}, 64'h1234_5000);
    check("u_imm64", r64_out_imm, 64'h0000_0000_1234_5000);
    check("u_fmt",   {61'b0, r32_out_fmt}, 64'd4);

    send(32'h800002B7, 3'b000, 32'h0000_1014);
    check("u_neg_imm64", r64_out_imm, 64'hFFFF_FFFF_8000_0000);
    check("u_neg_imm32", {32'b0, r32_out_imm}, 64'h8000_0000);

    send(32'h3002D073, 3'b000, 32'h0000_1018);
    check("z_imm", {32'b0, r32_out_imm}, 64'd5);
    check("z_fmt", {61'b0, r32_out_fmt}, 64'd5);

    send(32'h00B50533, 3'b000, 32'h0000_101C);
    check("none_imm", {32'b0, r32_out_imm}, 64'd0);
    check("none_fmt", {61'b0, r32_out_fmt}, 64'd6);
    check("none_ill", {63'b0, r32_out_illegal}, 64'd0);

    send(32'h0000007F, 3'b111, 32'h0000_1020);
    check("ill_flag", {63'b0, r32_out_illegal}, 64'd1);
    check("ill_imm",  {32'b0, r32_out_imm}, 64'd0);
    check("ext_ill",  {63'b0, ex_out_illegal}, 64'd1);

    send(32'h0000003B, 3'b000, 32'h0000_1024);
    check("reg32_ill32", {63'b0, r32_out_illegal}, 64'd1);
    check("reg32_fmt64", {61'b0, r64_out_fmt}, 64'd6);
    check("reg32_ill64", {63'b0, r64_out_illegal}, 64'd0);

    tick();
    check("idle_drained", {63'b0, r32_out_valid}, 64'd0);

    // Backpressure: A, B accepted, C held until space frees
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'hA;
    tick();
    check("bp_a_out", {32'b0, r32_out_tag}, 64'hA);
    check("bp_ready_after_a", {63'b0, r32_in_ready}, 64'd1);
    in_instr = 32'h00200093; in_tag = 32'hB;
    tick();
    check("bp_ready_after_b", {63'b0, r32_in_ready}, 64'd0);
    in_instr = 32'h00300093; in_tag = 32'hC;
    tick();
    check("bp_hold_tag", {32'b0, r32_out_tag}, 64'hA);
    check("bp_hold_imm", {32'b0, r32_out_imm}, 64'd1);
    check("bp_hold_ready", {63'b0, r32_in_ready}, 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_b_tag", {32'b0, r32_out_tag}, 64'hB);
    check("bp_b_imm", {32'b0, r32_out_imm}, 64'd2);
    tick();
    in_valid = 1'b0;
    check("bp_c_tag", {32'b0, r32_out_tag}, 64'hC);
    check("bp_c_imm", {32'b0, r32_out_imm}, 64'd3);
    tick();
    check("bp_end_valid", {63'b0, r32_out_valid}, 64'd0);

    // Flush with SKID full and an entry offered
    out_ready = 1'b0;
    send(32'h00400093, 3'b000, 32'hD);
    send(32'h00500093, 3'b000, 32'hE);
    check("fl_full", {63'b0, r32_in_ready}, 64'd0);
    in_valid = 1'b1; in_instr = 32'h00600093; in_tag = 32'hF;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", {63'b0, r32_out_valid}, 64'd0);
    check("fl_ready", {63'b0, r32_in_ready}, 64'd1);
    out_ready = 1'b1;
    tick();
    check("fl_no_ghost", {63'b0, r32_out_valid}, 64'd0);

    // Flush with an accepted entry in the same edge: the entry is dropped
    in_valid = 1'b1; in_instr = 32'h00700093; in_tag = 32'h10;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_acc_drop", {63'b0, r32_out_valid}, 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'hFFF00093, 3'b000, 32'h55);
    check("rs_pre_valid", {63'b0, r32_out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", {63'b0, r32_out_valid}, 64'd0);
    check("rs_imm",   {32'b0, r32_out_imm}, 64'd0);
    check("rs_tag",   {32'b0, r32_out_tag}, 64'd0);
    check("rs_ill",   {63'b0, r32_out_illegal}, 64'd0);
    #3 rst_n = 1'b1;
    tick();
    check("rs_ready", {63'b0, r32_in_ready}, 64'd1);
    check("rs_post_valid", {63'b0, r64_out_valid}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage: accepts a full 32-bit instruction plus a tag (typically the PC) over a valid/ready handshake. It derives the instruction format from the opcode, or takes an externally supplied format, and emits an XLEN-wide extended immediate one cycle later. A 2-entry output buffer (output register plus skid register) decouples decode from a stalling execute stage. It adds RV64 support, CSR zimm, R-type and illegal-opcode reporting, and a flush.

## Interface
- `XLEN`, default 32: datapath width; legal values are 32 and 64.
- `TAG_W`, default 32: width of the side-band tag carried with each instruction.
- `DECODE_OPCODE`, default 1: 1 means the format is decoded from the opcode; 0 means the format comes from `in_immsrc`.

- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: synchronous; drops all buffered entries.
- `in_valid`  in  1: input entry is valid.
- `in_ready`  out  1: block can accept an entry; equals !skid_valid.
- `in_instr`  in  32: instruction word.
- `in_immsrc`  in  3: format code; used only when DECODE_OPCODE=0.
- `in_tag`  in  TAG_W: passed through with the entry unchanged.
- `out_valid`  out  1: output entry is valid.
- `out_ready`  in  1: consumer accepts the output entry.
- `out_imm`  out  XLEN: extended immediate.
- `out_fmt`  out  3: resolved format code.
- `out_illegal`  out  1: opcode is unrecognised, or the code is 111 in external mode.
- `out_tag`  out  TAG_W: tag of the output entry.

## Operation
- Format codes: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110 NONE, 111 ILLEGAL.
- Opcode decode (DECODE_OPCODE=1):
  - 0000011, 0010011, 1100111 → I.
  - 0011011 → I when XLEN=64; ILLEGAL when XLEN=32.
  - 0100011 → S; 1100011 → B; 1101111 → J; 0110111 and 0010111 → U.
  - 1110011 → Z when instr[14]=1, otherwise I.
  - 0110011 → NONE; 0111011 → NONE when XLEN=64, ILLEGAL when XLEN=32.
  - Every other opcode → ILLEGAL.
- Immediate construction: I, S, B and J use standard RISC-V bit placement, sign-extended from instr[31] to XLEN.
- U: {instr[31:12], 12'b0}, then sign-extended from bit 31 to XLEN.
- Z: zero-extended instr[19:15].
- NONE and ILLEGAL: imm = 0. `out_illegal` is 1 only for ILLEGAL.
- Accept condition: in_valid && in_ready.
- Storage: output register (OUT) and skid register (SKID), each holding a valid bit plus {imm, fmt, illegal, tag}.
- Per-edge update, when flush=0:
  - OUT empty, or OUT drained this cycle (out_valid && out_ready): OUT loads SKID if SKID is valid, otherwise the accepted input. SKID then loads the accepted input if SKID was the source; otherwise SKID clears.
  - OUT full and not drained: an accepted input goes to SKID.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- Flush:
  - Both valid bits clear at the edge.
  - A simultaneous accept is discarded.
  - A simultaneous drain still counts as consumed by the consumer.
- `out_*` data is held stable while out_valid && !out_ready.

## Timing
- Latency is 1 cycle from accept to out_valid when OUT is empty.
- Throughput is 1 entry per cycle while out_ready=1.
- in_ready is combinational from the SKID valid flop only, with no path from in_valid or out_ready. This breaks the ready timing path.
- Reset values: out_valid 0, skid_valid 0, in_ready 1, out_imm 0, out_fmt 000, out_illegal 0, out_tag 0.
- Reset asserted mid-transfer discards both entries immediately, asynchronously.
- After flush, in_ready=1 and out_valid=0 on the following cycle.

## Structure
- Package `imm_pkg` holds:
  - the 3-bit format code constants;
  - the opcode constants (OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_REG, OP_REG32);
  - the XLEN legality check.
- Sub-module `imm_extend_core`: purely combinational format decode plus extension. Parameters: XLEN, DECODE_OPCODE. Inputs: instr, immsrc. Outputs: imm, fmt, illegal.
- The top level contains only the OUT/SKID handshake logic.

## Test plan
- Basic decode, XLEN=32, out_ready=1:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt I, one cycle after accept.
  - 0xFE112E23 → imm 0xFFFFFFFC, fmt S.
- U-type width:
  - XLEN=32: 0x123452B7 → 0x12345000.
  - XLEN=64: 0x800002B7 → 0xFFFFFFFF80000000.
- Z, NONE, ILLEGAL:
  - 0x3002D073 → imm 5, fmt Z.
  - 0x00B50533 → imm 0, fmt NONE.
  - 0x0000007F → illegal 1, imm 0.
  - 0x0000003B with XLEN=32 → illegal 1.
- Backpressure: out_ready=0 with entries A, B, C offered back-to-back.
  - A and B accepted; in_ready drops after B; C is held.
  - Raise out_ready: outputs appear as A, B, C on consecutive cycles, tags intact.
- Flush with SKID full and in_valid=1 in the same cycle: next cycle out_valid=0 and in_ready=1; the offered entry never appears.
- Reset mid-stream: drop rst_n while out_valid=1 → out_valid and all outputs read 0 immediately; in_ready=1 after release.
